// File: rtl/parallel_serial_shift_pkg.sv
// Shared constants for the serial link: FSM state encoding and default word width.
// The receiver side imports the same package so both ends agree on framing.
package parallel_serial_shift_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/parallel_serial_shift_if.sv
// Load handshake plus serial output bundle between a word source and the shifter.
interface parallel_serial_shift_if #(
    parameter int WIDTH = parallel_serial_shift_pkg::DEFAULT_WIDTH
);

    logic             en;
    logic             load_valid;
    logic [WIDTH-1:0] data_in;
    logic             load_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output en, load_valid, data_in,
        input  load_ready, bit_out, bit_valid, busy, done
    );

    modport slave (
        input  en, load_valid, data_in,
        output load_ready, bit_out, bit_valid, busy, done
    );

endinterface

// File: rtl/parallel_serial_shift.sv
// Parallel-to-serial shifter: captures a word in IDLE and emits it LSB first,
// one bit per enabled clock, then pulses done for a single cycle.
module parallel_serial_shift
    import parallel_serial_shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    parallel_serial_shift_if.slave  bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.load_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.en && (cnt == LAST)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath only moves on a load in IDLE or an enabled cycle in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        shreg <= bus.data_in;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (bus.en) begin
                        if (cnt == LAST) begin
                            shreg <= '0;
                            cnt   <= '0;
                        end else begin
                            shreg <= shreg >> 1;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.load_ready = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.bit_out    = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
            end
            SHIFT: begin
                bus.bit_valid = 1'b1;
                bus.bit_out   = shreg[0];
                bus.busy      = 1'b1;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_parallel_serial_shift.sv
// Self-checking bench: vector table, corner-case sequences and random traffic
// compared against a queue-based reference model of the serial link.
module tb_parallel_serial_shift;
    import parallel_serial_shift_pkg::*;

    localparam logic [4:0] IDLE_O = 5'b10000;
    localparam logic [4:0] DONE_O = 5'b00011;
    localparam logic [4:0] BIT1_O = 5'b01110;
    localparam logic [4:0] BIT0_O = 5'b00110;

    typedef struct {
        logic       en;
        logic       lv;
        logic [7:0] data;
        logic [4:0] exp_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst8;
    logic rst16;
    int   checks = 0;
    int   errors = 0;

    vec_t vecs[$];
    logic mq[$];
    logic done_pend;
    logic rx[$];

    always #5 clk = ~clk;

    parallel_serial_shift_if #(.WIDTH(8))  bus8 ();
    parallel_serial_shift_if #(.WIDTH(16)) bus16 ();

    parallel_serial_shift #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8)
    );

    parallel_serial_shift #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (bus16)
    );

    function automatic logic [4:0] dutOut8();
        return {bus8.load_ready, bus8.bit_out, bus8.bit_valid, bus8.busy, bus8.done};
    endfunction

    // Model view: a pending bit queue means a word is on the wire; an empty
    // queue with done_pend is the single completion cycle.
    function automatic logic [4:0] modelOut();
        if (mq.size() > 0) return {1'b0, mq[0], 1'b1, 1'b1, 1'b0};
        if (done_pend) return DONE_O;
        return IDLE_O;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic lv, input logic [7:0] d);
        logic tmp;
        if (!r && e && bus8.bit_valid) rx.push_back(bus8.bit_out);
        rst8            = r;
        bus8.en         = e;
        bus8.load_valid = lv;
        bus8.data_in    = d;
        if (r) begin
            mq.delete();
            done_pend = 1'b0;
        end else if (mq.size() > 0) begin
            if (e) begin
                tmp = mq.pop_front();
                if (mq.size() == 0) done_pend = 1'b1;
            end
        end else if (done_pend) begin
            done_pend = 1'b0;
        end else if (lv) begin
            for (int i = 0; i < 8; i++) mq.push_back(d[i]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput("model", 32'(dutOut8()), 32'(modelOut()));
    endtask

    function automatic logic [7:0] rxWord();
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < rx.size() && i < 8; i++) w[i] = rx[i];
        return w;
    endfunction

    task automatic addVec(input logic e, input logic lv, input logic [7:0] d, input logic [4:0] o);
        vec_t v;
        v.en = e; v.lv = lv; v.data = d; v.exp_out = o;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] w16;
        int          busy_cnt;
        int          done_cnt;

        rst8 = 1'b1; rst16 = 1'b1;
        bus8.en = 1'b0; bus8.load_valid = 1'b0; bus8.data_in = '0;
        bus16.en = 1'b0; bus16.load_valid = 1'b0; bus16.data_in = '0;
        done_pend = 1'b0;

        // Main stream plus a second stream with the link held saturated.
        w = 8'hA5;
        addVec(1'b1, 1'b1, w, IDLE_O);
        for (int i = 0; i < 8; i++) addVec(1'b1, 1'b0, 8'h00, w[i] ? BIT1_O : BIT0_O);
        addVec(1'b0, 1'b0, 8'h00, DONE_O);
        addVec(1'b0, 1'b0, 8'h00, IDLE_O);
        w = 8'h01;
        addVec(1'b0, 1'b1, w, IDLE_O);
        for (int i = 0; i < 8; i++) addVec(1'b1, 1'b1, 8'hFF, w[i] ? BIT1_O : BIT0_O);
        addVec(1'b0, 1'b1, 8'h80, DONE_O);
        addVec(1'b1, 1'b1, 8'h80, IDLE_O);
        w = 8'h80;
        for (int i = 0; i < 8; i++) addVec(1'b1, 1'b1, 8'h80, w[i] ? BIT1_O : BIT0_O);
        addVec(1'b0, 1'b0, 8'h00, DONE_O);
        addVec(1'b0, 1'b0, 8'h00, IDLE_O);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 32'(dutOut8()), 32'(IDLE_O));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        rst16 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            checkOutput($sformatf("vec%0d", i), 32'(dutOut8()), 32'(vecs[i].exp_out));
            applyStimulus(1'b0, vecs[i].en, vecs[i].lv, vecs[i].data);
        end

        // Slow bit rate: one enable every third cycle.
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C);
        rx.delete();
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus8.busy) busy_cnt++;
            if (bus8.done) done_cnt++;
            applyStimulus(1'b0, (k % 3) == 2, 1'b0, 8'h00);
        end
        checkOutput("slow_busy_cycles", busy_cnt, 25);
        checkOutput("slow_done_count", done_cnt, 1);
        checkOutput("slow_rx_word", 32'(rxWord()), 32'h3C);

        // Abort mid-word, then send a clean word.
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hF0);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus8.done) done_cnt++;
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hAA);
        tick();
        checkOutput("abort_idle", 32'(dutOut8()), 32'(IDLE_O));
        if (bus8.done) done_cnt++;
        checkOutput("abort_no_done", done_cnt, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h0F);
        rx.delete();
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus8.done) done_cnt++;
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        end
        checkOutput("after_abort_rx", 32'(rxWord()), 32'h0F);
        checkOutput("after_abort_done", done_cnt, 1);

        for (int k = 0; k < 1500; k++) begin
            tick();
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0, 8'($urandom));
        end

        // Wide instance: 16'h8001 at full rate.
        w16 = 16'h8001;
        @(negedge clk);
        checkOutput("w16_idle_ready", 32'(bus16.load_ready), 1);
        bus16.load_valid = 1'b1; bus16.data_in = w16; bus16.en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput($sformatf("w16_valid%0d", i), 32'(bus16.bit_valid), 1);
            checkOutput($sformatf("w16_bit%0d", i), 32'(bus16.bit_out), (i == 0 || i == 15) ? 1 : 0);
            bus16.load_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput("w16_done", 32'(bus16.done), 1);
        checkOutput("w16_cnt_wrap", 32'(dut16.cnt), 0);
        bus16.en = 1'b0;
        @(negedge clk);
        checkOutput("w16_back_idle", 32'({bus16.load_ready, bus16.busy, bus16.done}), 32'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parallel_serial_shift.md
PARALLEL_SERIAL_SHIFT -- requirements
Module: parallel_serial_shift

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  bit-rate enable; one bit is advanced per clk edge where en=1.
REQ-005 load_valid  input  1  parallel word offered.
REQ-006 data_in  input  WIDTH  parallel word; bit 0 is transmitted first.
REQ-007 load_ready  output  1  block accepts a word this cycle.
REQ-008 bit_out  output  1  serial data, LSB first.
REQ-009 bit_valid  output  1  bit_out holds a valid frame bit; the downstream serial-to-parallel receiver's enable SHALL be en AND bit_valid.
REQ-010 busy  output  1  word in flight (state SHIFT or DONE).
REQ-011 done  output  1  one-cycle pulse after the last bit is consumed.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; encoding SHALL be fixed as IDLE=0, SHIFT=1, DONE=2 (2-bit).
REQ-013 IDLE: load_ready=1, bit_valid=0, busy=0, bit_out=0; en SHALL be ignored.
REQ-014 IDLE with load_valid=1 at an edge: shreg<=data_in, cnt<=0, next state SHIFT; bit_valid=1 and bit_out=data_in[0] from the following cycle (1-cycle latency).
REQ-015 SHIFT: bit_out=shreg[0] combinationally, bit_valid=1, load_ready=0; load_valid SHALL be ignored and data_in not sampled.
REQ-016 SHIFT with en=1 and cnt<WIDTH-1: shreg<=shreg>>1 (zero fill at MSB), cnt<=cnt+1.
REQ-017 SHIFT with en=1 and cnt=WIDTH-1: shreg<=0, cnt<=0, next state DONE.
REQ-018 SHIFT with en=0: shreg, cnt and state SHALL hold; bit_out stable for any number of cycles.
REQ-019 Exactly WIDTH en cycles SHALL occur while in SHIFT per word, each presenting one bit, in order data_in[0]..data_in[WIDTH-1].
REQ-020 DONE: done=1, bit_valid=0, busy=1, load_ready=0, bit_out=0, for exactly one cycle; next state IDLE unconditionally.
REQ-021 Minimum word period: WIDTH en cycles + 2 clk cycles (load edge, DONE cycle); back-to-back loads are accepted on the IDLE cycle following DONE.
REQ-022 cnt width SHALL be $clog2(WIDTH); cnt SHALL never exceed WIDTH-1.
REQ-023 Simultaneous en=1 and load_valid=1 in IDLE: load taken, en ignored (no bit consumed).
REQ-024 en=1 on every cycle SHALL be legal and yield one bit per clk.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, shreg=0, cnt=0, overriding load_valid and en.
REQ-026 Reset values: load_ready=1 (after the edge), bit_out=0, bit_valid=0, busy=0, done=0.
REQ-027 rst asserted mid-SHIFT SHALL abort the word with no done pulse; remaining bits are discarded.

Structure
REQ-028 Shared package SHALL hold the FSM state constants (IDLE/SHIFT/DONE) and the default word width constant (8), reused by the receiver side.
REQ-029 Single module; no sub-module: shift register, counter and FSM are local.
REQ-030 All outputs except bit_out SHALL be decoded from the registered state only; no combinational path from inputs to outputs.

Verification
REQ-031 Load 8'hA5, en=1 every cycle -> bit_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive bit_valid cycles; done pulses once, cycle after 8th bit.
REQ-032 Load 8'h3C, en=1 every 3rd cycle -> each bit held 3 cycles; busy high for 8*3+1 cycles; loop into receiver reproduces 8'h3C.
REQ-033 load_valid=1 with 8'hFF during SHIFT of 8'h01 -> load_ready=0, transmitted word stays 8'h01, 8'hFF not captured.
REQ-034 rst=1 after 4th bit of 8'hF0 -> next cycle IDLE, bit_out=0, no done; subsequent 8'h0F transmits cleanly.
REQ-035 load_valid held high continuously, data 8'h01 then 8'h80 -> two words back-to-back, one IDLE cycle between done and next bit_valid.
REQ-036 WIDTH=16, load 16'h8001, en=1 every cycle -> bit 0 and bit 15 high, 14 zeros between; cnt wraps to 0 at DONE.
